data_memory_ctl: RTL
====================

# data_memory_ctl

Parametrised single-port data memory with a request/response handshake, replacing the fixed 8-bit, 256-word, combinational-read data memory. After reset, an internal sequencer sweeps every word, writing either the standard test-program preload image or zero. Only then does the block accept processor traffic. Reads return after a fixed, configurable pipeline latency. It sits between the datapath's memory stage and the processor's memory-access control.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- READ_LAT, 1, read latency in cycles, legal range 1..4
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present this cycle
- req_ready  out  1  block can accept a request; 0 during init
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data valid; single-cycle pulse per accepted read
- rsp_data  out  DATA_W  read data; held at last value when rsp_valid = 0
- init_busy  out  1  init sweep in progress

## Operation
- States:
  - INIT: sweep pointer runs 0..DEPTH-1, writing one word per cycle; on pointer = DEPTH-1, go to RUN.
  - RUN: serve requests. There is no exit except reset.
- Request acceptance:
  - A request is accepted when req_valid && req_ready.
  - One request per cycle; there is no request queue.
- Accepted write: word[req_addr] <= req_wdata at that edge. Writes produce no response.
- Accepted read:
  - Array is sampled at the accept edge.
  - Result travels a READ_LAT-deep valid/data shift pipeline to rsp_valid/rsp_data.
- Read-after-write:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Reads are never combinational from the array.
- Responses:
  - Returned in request order.
  - There is no rsp backpressure; the consumer must take every pulse.
- Requests presented during INIT:
  - They are ignored (req_ready = 0) and have no effect on the array.
- Address/width:
  - req_addr is used unmodified; every value addresses a distinct word, with no wrap logic required.
  - Preload values are zero-extended to DATA_W.
  - Preload entries at addresses >= DEPTH are dropped.

## Timing
- Reset values:
  - req_ready = 0, init_busy = 1, rsp_valid = 0, rsp_data = 0.
  - State = INIT, sweep pointer = 0.
- Init duration:
  - Exactly DEPTH cycles after reset deassertion.
  - init_busy falls and req_ready rises on the same edge that writes word DEPTH-1.
- Read latency: a read accepted at edge N yields rsp_valid = 1 in the cycle after edge N+READ_LAT-1. For READ_LAT = 1, that is the cycle immediately after acceptance.
- Back-to-back reads give back-to-back rsp_valid pulses at full throughput.
- Reset mid-operation:
  - In-flight responses are discarded; rsp_valid drops immediately.
  - Init restarts from pointer 0 and rewrites the whole array.

## Configuration
- DMEM_PRELOAD_EN defined:
  - Init writes the preload image at addresses 100..121: 10, 7, 75, 9, 3, 4, 5, 6, 7, 8, 9, 90, 10, 12, 13, 14, 15, 120, 1, 2, 3, 4.
  - All other words are written 0.
- DMEM_PRELOAD_EN undefined:
  - Init writes 0 to every word.
  - Preload table and lookup logic are not compiled.
  - Init duration is unchanged.

## Structure
- Shared package dmem_pkg holds:
  - state enum (INIT, RUN);
  - PRELOAD_BASE = 100, PRELOAD_LEN = 22;
  - the 8-bit preload value array constant.
- Sub-module dmem_preload_rom: combinational lookup, sweep pointer -> {hit, value}. It is instantiated only under DMEM_PRELOAD_EN.

## Test plan
- Reset, hold req_valid = 1:
  - req_ready stays 0 for 256 cycles (defaults) and init_busy falls on cycle 256.
  - No write lands: after init, a read of address 5 returns 0.
- With DMEM_PRELOAD_EN, after init:
  - Reads of 100, 102, 111, 121 return 10, 75, 90, 4, each one cycle after accept.
  - A read of 99 returns 0.
- Write 0xA5 to addr 200, then read 200 on the next cycle -> rsp_data = 0xA5 with rsp_valid one cycle later.
- READ_LAT = 3, four back-to-back reads of 100..103:
  - rsp_valid high for 4 consecutive cycles starting 3 cycles after the first accept.
  - Data 10, 7, 75, 9 in order.
- Reset asserted while two reads are in flight (READ_LAT = 3):
  - rsp_valid = 0 immediately and no stale pulse follows.
  - Init repeats: a write of 0x33 to addr 104 before the reset reads back 3 (preload) or 0 (no preload) afterwards.
- DATA_W = 16, ADDR_W = 4:
  - Init lasts 16 cycles; all words read 0, since the preload addresses are out of range.
  - Write 0xBEEF to addr 15 reads back 0xBEEF.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory controller.
//   - state_t       : controller sequencer states (INIT sweep, RUN service)
//   - PRELOAD_BASE  : first word address of the test-program preload image
//   - PRELOAD_LEN   : number of words in the preload image
//   - PRELOAD_VAL   : 8-bit preload values, index 0 lands at PRELOAD_BASE
package dmem_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PRELOAD_BASE = 100;
  localparam int PRELOAD_LEN  = 22;

  localparam logic [7:0] PRELOAD_VAL [PRELOAD_LEN] = '{
    8'd10, 8'd7,  8'd75, 8'd9,  8'd3,   8'd4,  8'd5,  8'd6,
    8'd7,  8'd8,  8'd9,  8'd90, 8'd10,  8'd12, 8'd13, 8'd14,
    8'd15, 8'd120, 8'd1, 8'd2,  8'd3,   8'd4
  };

endpackage

// File: rtl/dmem_preload_rom.sv
// dmem_preload_rom: combinational preload image lookup used by the init sweep.
// Only instantiated when DMEM_PRELOAD_EN is defined.
// Ports:
//   addr  in  ADDR_W  sweep pointer (word address being initialised)
//   hit   out 1       addr falls inside the preload image
//   value out DATA_W  zero-extended preload value (0 when no hit)
module dmem_preload_rom
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] value
);

  // Compare against every image slot; addresses beyond DEPTH can never match,
  // so entries that do not fit the configured array are dropped naturally.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = 0; i < PRELOAD_LEN; i++) begin
      hit   = hit | (32'(addr) == 32'(PRELOAD_BASE + i));
      value = value | ((32'(addr) == 32'(PRELOAD_BASE + i)) ?
                       DATA_W'(PRELOAD_VAL[i]) : DATA_W'(0));
    end
  end

endmodule

// File: rtl/data_memory_ctl.sv
// data_memory_ctl: single-port data memory with request/response handshake.
// After reset a sequencer writes every word (preload image or zero), then the
// block serves one request per cycle. Reads return through a READ_LAT-deep
// pipeline; writes produce no response.
// Build option: DMEM_PRELOAD_EN -- init writes the test-program preload image
// at addresses 100..121 instead of all zeros.
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   req_valid  in   request present
//   req_ready  out  request can be accepted (0 during init)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle pulse per accepted read
//   rsp_data   out  read data, holds last value between pulses
//   init_busy  out  init sweep in progress
module data_memory_ctl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              vpipe_r [READ_LAT];
  logic [DATA_W-1:0] dpipe_r [READ_LAT];

  logic              init_we_s;
  logic              rd_accept_s;
  logic              wr_accept_s;
  logic [DATA_W-1:0] init_data_s;

`ifdef DMEM_PRELOAD_EN
  logic              rom_hit_s;
  logic [DATA_W-1:0] rom_value_s;

  dmem_preload_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .addr  (ptr_r),
    .hit   (rom_hit_s),
    .value (rom_value_s)
  );

  // Init word: preload image where it applies, zero elsewhere.
  always_comb begin
    if (rom_hit_s) begin
      init_data_s = rom_value_s;
    end else begin
      init_data_s = '0;
    end
  end
`else
  // Init word: without the preload image every word is cleared.
  always_comb begin
    init_data_s = '0;
  end
`endif

  // Request qualification; req_ready is only high in RUN, so init traffic is inert.
  always_comb begin
    init_we_s   = (state_r == INIT);
    rd_accept_s = req_valid && req_ready && !req_write;
    wr_accept_s = req_valid && req_ready && req_write;
  end

  // Sequencer: sweep every word once after reset, then serve requests forever.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= INIT;
      ptr_r     <= '0;
      init_busy <= 1'b1;
      req_ready <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          if (ptr_r == LAST_ADDR) begin
            state_r   <= RUN;
            init_busy <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r   <= INIT;
          ptr_r     <= '0;
          init_busy <= 1'b1;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; no reset because the init sweep rewrites every word.
  always_ff @(posedge clock) begin
    if (init_we_s) begin
      mem_r[ptr_r] <= init_data_s;
    end else if (wr_accept_s) begin
      mem_r[req_addr] <= req_wdata;
    end
  end

  // Read pipeline: array sampled at the accept edge, then shifted READ_LAT-1
  // more stages. Data stages only advance with a valid so the output holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < READ_LAT; k++) begin
        vpipe_r[k] <= 1'b0;
        dpipe_r[k] <= '0;
      end
    end else begin
      vpipe_r[0] <= rd_accept_s;
      if (rd_accept_s) begin
        dpipe_r[0] <= mem_r[req_addr];
      end
      for (int k = 1; k < READ_LAT; k++) begin
        vpipe_r[k] <= vpipe_r[k-1];
        if (vpipe_r[k-1]) begin
          dpipe_r[k] <= dpipe_r[k-1];
        end
      end
    end
  end

  assign rsp_valid = vpipe_r[READ_LAT-1];
  assign rsp_data  = dpipe_r[READ_LAT-1];

endmodule
